sbox_decrypt_sched: RTL and testbench

Sequencing controller for the inverse-substitution layer of the 64-bit decryption datapath. It accepts one 64-bit ciphertext state over a valid/ready handshake. It time-multiplexes a configurable number of 4-bit inverse S-box lanes across the 16 nibbles of that state, then presents the substituted state on a valid/ready output port. It sits between the round-key/permutation stages and lets area be traded against latency through one parameter.

---
 rtl/sbox_decrypt_sched.sv | 129 ++++++++++++
 tb/tb_sbox_decrypt_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_decrypt_sched.sv
// Inverse S-box sequencer: accepts one 64-bit state, substitutes LANES nibbles
// per cycle in place, then holds the result until the downstream accepts it.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a block; in_ready high
// S_RUN  | substituting nibble group `beat`, LSB group first
// S_DONE | result held on out_data; out_valid high until out_ready
module sbox_decrypt_sched #(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [3:0]  beat
);

    localparam int         NBEATS    = 16 / LANES;
    localparam int         GW        = 4 * LANES;
    localparam logic [3:0] LAST_BEAT = 4'(NBEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [3:0]  beat_q, beat_d;
    logic [GW-1:0] grp_in;
    logic [GW-1:0] grp_out;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    always_comb begin
        grp_in = state_q[int'(beat_q) * GW +: GW];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign grp_out[4*l +: 4] = inv_sbox(grp_in[4*l +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= 64'h0;
            beat_q  <= 4'h0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        beat_d  = beat_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_data;
                    beat_d  = 4'h0;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                state_d[int'(beat_q) * GW +: GW] = grp_out;
                if (beat_q == LAST_BEAT) begin
                    beat_d = 4'h0;
                    fsm_d  = S_DONE;
                end else begin
                    beat_d = beat_q + 4'h1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so no input-to-output path exists.
    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q != S_IDLE);
    assign beat      = beat_q;
    assign out_data  = state_q;

`ifndef SYNTHESIS
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid));
    a_beat_idle: assert property (@(posedge clk) disable iff (rst)
        (fsm_q != S_RUN) |-> (beat_q == 4'h0));
`endif

endmodule

// File: tb/tb_sbox_decrypt_sched.sv
// Directed and random checks of the inverse S-box sequencer across lane counts.
module tb_sbox_decrypt_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic [3:0]  beat;

    logic             sw_valid;
    logic [63:0]      sw_in;
    logic [3:0]       sw_ir;
    logic [3:0]       sw_ov;
    logic [3:0]       sw_busy;
    logic [3:0][63:0] sw_out;
    logic [3:0][3:0]  sw_beat;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    int overlap = 0;
    int acc_cyc[$];
    logic [63:0] exp_q[$];
    logic sb_on = 1'b0;

    logic [3:0] inv_tab [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                 4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    always #5 clk = ~clk;

    sbox_decrypt_sched #(.LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .beat(beat));

    sbox_decrypt_sched #(.LANES(1)) dut_l1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[0]),
        .in_data(sw_in), .out_valid(sw_ov[0]), .out_ready(1'b1),
        .out_data(sw_out[0]), .busy(sw_busy[0]), .beat(sw_beat[0]));

    sbox_decrypt_sched #(.LANES(2)) dut_l2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[1]),
        .in_data(sw_in), .out_valid(sw_ov[1]), .out_ready(1'b1),
        .out_data(sw_out[1]), .busy(sw_busy[1]), .beat(sw_beat[1]));

    sbox_decrypt_sched #(.LANES(8)) dut_l8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[2]),
        .in_data(sw_in), .out_valid(sw_ov[2]), .out_ready(1'b1),
        .out_data(sw_out[2]), .busy(sw_busy[2]), .beat(sw_beat[2]));

    sbox_decrypt_sched #(.LANES(16)) dut_l16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[3]),
        .in_data(sw_in), .out_valid(sw_ov[3]), .out_ready(1'b1),
        .out_data(sw_out[3]), .busy(sw_busy[3]), .beat(sw_beat[3]));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_tab[x[4*i +: 4]];
        return y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are judged at the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready && out_valid) overlap++;
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                if (sb_on) begin
                    exp_q.push_back(model(in_data));
                    n_acc++;
                end
            end
            if (sb_on && out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check_val("sb_spurious", 64'd1, 64'd0);
                else check_val("sb_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        int lat;
        int na;
        int sw_lat[4];
        logic [63:0] sw_cap[4];
        int guard;

        rst = 1'b1; in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b0;
        sw_valid = 1'b0; sw_in = 64'h0;
        step(); step();
        rst = 1'b0;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data", out_data, 64'h0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_beat", 64'(beat), 64'd0);

        // Basic block, 4 lanes
        in_data = 64'h0123_4567_89AB_CDEF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_val("run_busy", 64'(busy), 64'd1);
        check_val("run_in_ready", 64'(in_ready), 64'd0);
        check_val("run_beat0", 64'(beat), 64'd0);
        wait_ov(lat);
        check_val("lat_l4", 64'(lat), 64'd4);
        check_val("data_l4", out_data, 64'h5EF8_C12D_B463_079A);
        check_val("done_beat", 64'(beat), 64'd0);
        out_ready = 1'b1;
        step();
        check_val("idle_in_ready", 64'(in_ready), 64'd1);
        check_val("idle_out_valid", 64'(out_valid), 64'd0);

        // Back-to-back blocks with out_ready tied high
        in_data = 64'h0; in_valid = 1'b1;
        step();
        in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_ov(lat);
        check_val("data_zero", out_data, 64'h5555_5555_5555_5555);
        step();
        step();
        in_valid = 1'b0;
        check_val("b2b_busy", 64'(busy), 64'd1);
        wait_ov(lat);
        check_val("data_ones", out_data, 64'hAAAA_AAAA_AAAA_AAAA);
        check_val("accept_spacing", 64'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 64'd6);
        step();

        // Downstream stall with input noise
        out_ready = 1'b0;
        in_data = 64'h0123_4567_89AB_CDEF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_ov(lat);
        na = acc_cyc.size();
        for (int i = 0; i < 10; i++) begin
            in_data = {$urandom, $urandom};
            in_valid = (i % 2 == 0);
            step();
            check_val("stall_data", out_data, 64'h5EF8_C12D_B463_079A);
            check_val("stall_in_ready", 64'(in_ready), 64'd0);
            check_val("stall_out_valid", 64'(out_valid), 64'd1);
        end
        check_val("stall_no_accept", 64'(acc_cyc.size()), 64'(na));
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check_val("stall_release", 64'(in_ready), 64'd1);

        // Reset in the middle of RUN
        in_data = 64'h0123_4567_89AB_CDEF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        check_val("mid_beat2", 64'(beat), 64'd2);
        rst = 1'b1; in_valid = 1'b1; in_data = 64'hFEDC_BA98_7654_3210;
        step();
        rst = 1'b0;
        check_val("mid_rst_ov", 64'(out_valid), 64'd0);
        check_val("mid_rst_ir", 64'(in_ready), 64'd1);
        check_val("mid_rst_data", out_data, 64'h0);
        step();
        in_valid = 1'b0;
        wait_ov(lat);
        check_val("mid_lat", 64'(lat), 64'd4);
        check_val("mid_data", out_data, 64'hA970_364B_D21C_8FE5);
        step();

        // Lane-count sweep
        sw_in = 64'h0123_4567_89AB_CDEF; sw_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin sw_lat[k] = 0; sw_cap[k] = 64'h0; end
        step();
        sw_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (sw_ov[k] && sw_lat[k] == 0) begin
                    sw_lat[k] = n;
                    sw_cap[k] = sw_out[k];
                end
            end
        end
        check_val("lat_l1", 64'(sw_lat[0]), 64'd16);
        check_val("lat_l2", 64'(sw_lat[1]), 64'd8);
        check_val("lat_l8", 64'(sw_lat[2]), 64'd2);
        check_val("lat_l16", 64'(sw_lat[3]), 64'd1);
        for (int k = 0; k < 4; k++) check_val("sweep_data", sw_cap[k], 64'h5EF8_C12D_B463_079A);

        // Random traffic against the nibble table model
        sb_on = 1'b1;
        guard = 0;
        while (guard < 40000 && (n_acc < 1000 || exp_q.size() != 0)) begin
            in_valid  = (n_acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        in_valid = 1'b0;
        sb_on = 1'b0;
        check_val("rand_accepts", 64'(n_acc), 64'd1000);
        check_val("rand_outputs", 64'(n_out), 64'd1000);
        check_val("rand_pending", 64'(exp_q.size()), 64'd0);
        check_val("no_overlap", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
